// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM encodings and
// the byte-address to word-index shift helper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

   // Number of byte-offset address bits below the register index.
   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage for the AXI-Lite slave: strobe-merged byte writes, a
// one-cycle write pulse per register and a registered read mux.
module axi_lite_reg_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = 32
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [DATA_WIDTH/8-1:0]      wr_strb,
   input  logic                         rd_en,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]          reg_wr_pulse,
   output logic [DATA_WIDTH-1:0]        rd_data
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs_arr [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_sel;
   logic [DATA_WIDTH-1:0] rd_data_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic                  hit;
         logic [DATA_WIDTH-1:0] q_reg;
         logic                  pulse_reg;

         assign hit = wr_en && (wr_idx == IDX_W'(gi));

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               q_reg     <= '0;
               pulse_reg <= 1'b0;
            end else begin
               pulse_reg <= hit;
               for (int k = 0; k < STRB_W; k++) begin
                  if (hit && wr_strb[k])
                     q_reg[k*8 +: 8] <= wr_data[k*8 +: 8];
               end
            end
         end

         assign regs_arr[gi]                            = q_reg;
         assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH]   = q_reg;
         assign reg_wr_pulse[gi]                        = pulse_reg;
      end
   endgenerate

   // An index that matches no register falls through to zero read data.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i))
            rd_sel = regs_arr[i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         rd_data_reg <= '0;
      else if (rd_en)
         rd_data_reg <= rd_sel;
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register-bank slave with independent AW/W arrival handling.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with DECERR.
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int LSB    = addr_lsb(DATA_WIDTH);
   localparam int STRB_W = DATA_WIDTH / 8;
`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] OOR_RESP = RESP_DECERR;
`else
   localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

   wr_state_e wr_state_reg, wr_state_next;
   rd_state_e rd_state_reg, rd_state_next;

   logic                  aw_held_reg, w_held_reg;
   logic [ADDR_WIDTH-1:0] awaddr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [STRB_W-1:0]     wstrb_reg;
   logic [1:0]            bresp_reg, rresp_reg;

   logic                  aw_hs, w_hs, ar_hs, b_hs, commit;
   logic                  wr_in_range, rd_in_range;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;

   assign awready = (wr_state_reg == WR_IDLE) && !aw_held_reg;
   assign wready  = (wr_state_reg == WR_IDLE) && !w_held_reg;
   assign bvalid  = (wr_state_reg == WR_RESP);
   assign arready = (rd_state_reg == RD_IDLE);
   assign rvalid  = (rd_state_reg == RD_DATA);
   assign bresp   = bresp_reg;
   assign rresp   = rresp_reg;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;
   assign b_hs  = bvalid && bready;

   // A channel counts as available if already held or handshaking right now.
   assign commit = (wr_state_reg == WR_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

   assign wr_addr     = aw_held_reg ? awaddr_reg : awaddr;
   assign wr_data     = w_held_reg ? wdata_reg : wdata;
   assign wr_strb     = w_held_reg ? wstrb_reg : wstrb;
   assign wr_idx      = wr_addr >> LSB;
   assign rd_idx      = araddr >> LSB;
   assign wr_in_range = wr_idx < ADDR_WIDTH'(NUM_REGS);
   assign rd_in_range = rd_idx < ADDR_WIDTH'(NUM_REGS);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_reg <= WR_IDLE;
         rd_state_reg <= RD_IDLE;
         aw_held_reg  <= 1'b0;
         w_held_reg   <= 1'b0;
         awaddr_reg   <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         bresp_reg    <= RESP_OKAY;
         rresp_reg    <= RESP_OKAY;
      end else begin
         wr_state_reg <= wr_state_next;
         rd_state_reg <= rd_state_next;
         if (b_hs) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held_reg <= 1'b1;
               awaddr_reg  <= awaddr;
            end
            if (w_hs) begin
               w_held_reg <= 1'b1;
               wdata_reg  <= wdata;
               wstrb_reg  <= wstrb;
            end
         end
         if (commit)
            bresp_reg <= wr_in_range ? RESP_OKAY : OOR_RESP;
         if (ar_hs)
            rresp_reg <= rd_in_range ? RESP_OKAY : OOR_RESP;
      end
   end

   always_comb begin
      wr_state_next = wr_state_reg;
      rd_state_next = rd_state_reg;
      case (wr_state_reg)
         WR_IDLE: if (commit) wr_state_next = WR_RESP;
         WR_RESP: if (bready) wr_state_next = WR_IDLE;
         default: wr_state_next = WR_IDLE;
      endcase
      case (rd_state_reg)
         RD_IDLE: if (arvalid) rd_state_next = RD_DATA;
         RD_DATA: if (rready)  rd_state_next = RD_IDLE;
         default: rd_state_next = RD_IDLE;
      endcase
   end

   axi_lite_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (ADDR_WIDTH)
   ) u_bank (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .wr_en        (commit && wr_in_range),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .wr_strb      (wr_strb),
      .rd_en        (ar_hs),
      .rd_idx       (rd_idx),
      .regs_out     (regs_out),
      .reg_wr_pulse (reg_wr_pulse),
      .rd_data      (rdata)
   );

endmodule
